// File: rtl/pipe_bus_if.sv
// rtl/pipe_bus_if.sv - pipeline memory port to Wishbone bus master bridge
// Holds the pipeline with a stall request while a bus cycle is outstanding.
module pipe_bus_if #(
  parameter int STALL_BIT = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_FOR_STALL} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        stb_q, stb_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        stallreq;
  logic [31:0] cpu_data;
  logic        own_stall;
  logic        stall_unused;

  assign own_stall    = stall_i[STALL_BIT];
  assign stall_unused = ^stall_i;

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    sel_d    = sel_q;
    stb_d    = stb_q;
    rbuf_d   = rbuf_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    stallreq = 1'b0;
    cpu_data = '0;
    unique case (state_q)
      IDLE: begin
        stallreq = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          adr_d   = cpu_addr_i;
          dat_d   = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (flush_i || wb_ack_i || cnt_q == CNT_LAST) begin
          adr_d   = '0;
          dat_d   = '0;
          we_d    = 1'b0;
          sel_d   = '0;
          stb_d   = 1'b0;
          state_d = IDLE;
        end
        // Flush wins over a coincident ack: the returned data is discarded.
        if (flush_i) begin
          rbuf_d = '0;
        end else if (wb_ack_i) begin
          cpu_data = we_q ? 32'h0 : wb_dat_i;
          if (!we_q) rbuf_d = wb_dat_i;
          if (own_stall) state_d = WAIT_FOR_STALL;
        end else if (cnt_q == CNT_LAST) begin
          err_d = 1'b1;
        end else begin
          cnt_d    = cnt_q + 8'd1;
          stallreq = 1'b1;
        end
      end
      WAIT_FOR_STALL: begin
        // Access already completed; replay the data until the stage advances.
        cpu_data = rbuf_q;
        if (flush_i) rbuf_d = '0;
        if (!own_stall || flush_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      stb_q   <= 1'b0;
      rbuf_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      stb_q   <= stb_d;
      rbuf_q  <= rbuf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = sel_q;
  assign wb_stb_o   = stb_q;
  assign wb_cyc_o   = stb_q;
  assign bus_err_o  = err_q;
  assign stallreq_o = rst & stallreq;
  assign cpu_data_o = rst ? cpu_data : 32'h0;

endmodule

// File: tb/tb_pipe_bus_if.sv
// tb/tb_pipe_bus_if.sv - table vectors, corner sequences and random run vs access model
module tb_pipe_bus_if;

  localparam int SB = 1;
  localparam int TO = 4;

  logic        clk, rst;
  logic [5:0]  stall_i;
  logic        flush_i, cpu_ce_i, cpu_we_i, wb_ack_i;
  logic [31:0] cpu_addr_i, cpu_data_i, wb_dat_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o, wb_adr_o, wb_dat_o;
  logic        stallreq_o, bus_err_o, wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0]  wb_sel_o;

  pipe_bus_if #(.STALL_BIT(SB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Access-level reference: one outstanding access record plus a parked result.
  logic        m_out, m_park, m_err, m_we;
  int          m_wait;
  logic [31:0] m_buf, m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        exp_sr;
  logic [31:0] exp_rd;

  task automatic model_reset();
    m_out = 0; m_park = 0; m_err = 0; m_we = 0; m_wait = 0;
    m_buf = 0; m_adr = 0; m_dat = 0; m_sel = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    exp_sr = 0;
    exp_rd = 0;
    if (m_park) exp_rd = m_buf;
    else if (m_out) begin
      if (!flush_i && wb_ack_i) exp_rd = m_we ? 32'h0 : wb_dat_i;
      else if (!flush_i && m_wait != TO - 1) exp_sr = 1;
    end else exp_sr = cpu_ce_i & ~flush_i;
    chk("stallreq", stallreq_o, exp_sr);
    chk("cpu_data", cpu_data_o, exp_rd);
    chk("wb_stb", wb_stb_o, m_out);
    chk("wb_cyc", wb_cyc_o, m_out);
    chk("wb_adr", wb_adr_o, m_adr);
    chk("wb_dat", wb_dat_o, m_dat);
    chk("wb_we", wb_we_o, m_we);
    chk("wb_sel", wb_sel_o, m_sel);
    chk("bus_err", bus_err_o, m_err);
  endtask

  task automatic advance();
    logic ended;
    ended = 0;
    m_err = 0;
    if (m_park) begin
      if (flush_i) m_buf = 0;
      if (!stall_i[SB] || flush_i) m_park = 0;
    end else if (m_out) begin
      if (flush_i) begin
        m_buf = 0; ended = 1;
      end else if (wb_ack_i) begin
        if (!m_we) m_buf = wb_dat_i;
        m_park = stall_i[SB]; ended = 1;
      end else if (m_wait == TO - 1) begin
        m_err = 1; ended = 1;
      end else m_wait++;
      if (ended) begin
        m_out = 0; m_adr = 0; m_dat = 0; m_we = 0; m_sel = 0;
      end
    end else if (cpu_ce_i && !flush_i) begin
      m_out = 1; m_wait = 0;
      m_adr = cpu_addr_i; m_dat = cpu_data_i; m_we = cpu_we_i; m_sel = cpu_sel_i;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ce, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] rdata;
    logic [5:0]  stall;
    logic        flush;
    logic        e_sr;
    logic [31:0] e_rd;
    logic        e_stb, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic ce, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] sel, input logic ack,
                             input logic [31:0] rdata, input logic [5:0] stall, input logic flush,
                             input logic e_sr, input logic [31:0] e_rd, input logic e_stb,
                             input logic e_err);
    vec_t r;
    r.ce = ce; r.we = we; r.addr = addr; r.wdata = wdata; r.sel = sel; r.ack = ack;
    r.rdata = rdata; r.stall = stall; r.flush = flush; r.e_sr = e_sr; r.e_rd = e_rd;
    r.e_stb = e_stb; r.e_err = e_err;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    cpu_ce_i = x.ce; cpu_we_i = x.we; cpu_addr_i = x.addr; cpu_data_i = x.wdata;
    cpu_sel_i = x.sel; wb_ack_i = x.ack; wb_dat_i = x.rdata; stall_i = x.stall;
    flush_i = x.flush;
  endtask

  initial begin
    rst = 0; cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h10; cpu_data_i = 0;
    cpu_sel_i = 4'hf; wb_ack_i = 0; wb_dat_i = 0; stall_i = 0; flush_i = 0;
    model_reset();
    #1;
    chk("rst_stallreq", stallreq_o, 0);
    chk("rst_cpu_data", cpu_data_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_err", bus_err_o, 0);
    @(posedge clk); @(posedge clk); #1;
    cpu_ce_i = 0;
    rst = 1;

    //          ce we addr          wdata         sel ack rdata         stall     fl  sr rd            stb err
    // single read, ack on third busy cycle
    vecs.push_back(v(1, 0, 32'h100, 32'h0,        4'hf, 0, 32'h0,        6'h00, 0, 1, 32'h0,        0, 0));
    vecs.push_back(v(1, 0, 32'h100, 32'h0,        4'hf, 0, 32'h0,        6'h00, 0, 1, 32'h0,        1, 0));
    vecs.push_back(v(1, 0, 32'h100, 32'h0,        4'hf, 0, 32'h0,        6'h00, 0, 1, 32'h0,        1, 0));
    vecs.push_back(v(1, 0, 32'h100, 32'h0,        4'hf, 1, 32'hDEADBEEF, 6'h00, 0, 0, 32'hDEADBEEF, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        6'h00, 0, 0, 32'h0,        0, 0));
    // write, ack returns zero data
    vecs.push_back(v(1, 1, 32'h200, 32'h12345678, 4'h3, 0, 32'h0,        6'h00, 0, 1, 32'h0,        0, 0));
    vecs.push_back(v(1, 1, 32'h200, 32'h12345678, 4'h3, 0, 32'h0,        6'h00, 0, 1, 32'h0,        1, 0));
    vecs.push_back(v(1, 1, 32'h200, 32'h12345678, 4'h3, 1, 32'hFFFFFFFF, 6'h00, 0, 0, 32'h0,        1, 0));
    vecs.push_back(v(0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        6'h00, 0, 0, 32'h0,        0, 0));
    // read acked while another stage holds the pipeline
    vecs.push_back(v(1, 0, 32'h300, 32'h0,        4'hf, 0, 32'h0,        6'h00, 0, 1, 32'h0,        0, 0));
    vecs.push_back(v(1, 0, 32'h300, 32'h0,        4'hf, 1, 32'hA5A50001, 6'h1f, 0, 0, 32'hA5A50001, 1, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(1, 0, 32'h300, 32'h0,      4'hf, 0, 32'h0,        6'h1f, 0, 0, 32'hA5A50001, 0, 0));
    vecs.push_back(v(1, 0, 32'h300, 32'h0,        4'hf, 0, 32'h0,        6'h00, 0, 0, 32'hA5A50001, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        6'h00, 0, 0, 32'h0,        0, 0));
    // flush coincident with ack, then a fresh access
    vecs.push_back(v(1, 0, 32'h400, 32'h0,        4'hf, 0, 32'h0,        6'h00, 0, 1, 32'h0,        0, 0));
    vecs.push_back(v(1, 0, 32'h400, 32'h0,        4'hf, 0, 32'h0,        6'h00, 0, 1, 32'h0,        1, 0));
    vecs.push_back(v(1, 0, 32'h400, 32'h0,        4'hf, 1, 32'h00001111, 6'h00, 1, 0, 32'h0,        1, 0));
    vecs.push_back(v(0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        6'h00, 0, 0, 32'h0,        0, 0));
    vecs.push_back(v(1, 0, 32'h404, 32'h0,        4'hf, 0, 32'h0,        6'h00, 0, 1, 32'h0,        0, 0));
    vecs.push_back(v(0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h00002222, 6'h00, 0, 0, 32'h00002222, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        6'h00, 0, 0, 32'h0,        0, 0));
    // timeout after four busy cycles
    vecs.push_back(v(1, 0, 32'h500, 32'h0,        4'hf, 0, 32'h0,        6'h00, 0, 1, 32'h0,        0, 0));
    vecs.push_back(v(0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        6'h00, 0, 1, 32'h0,        1, 0));
    vecs.push_back(v(0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        6'h00, 0, 1, 32'h0,        1, 0));
    vecs.push_back(v(0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        6'h00, 0, 1, 32'h0,        1, 0));
    vecs.push_back(v(0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        6'h00, 0, 0, 32'h0,        1, 0));
    vecs.push_back(v(0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        6'h00, 0, 0, 32'h0,        0, 1));
    vecs.push_back(v(0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        6'h00, 0, 0, 32'h0,        0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      sample();
      chk($sformatf("vec%0d_stallreq", i), stallreq_o, vecs[i].e_sr);
      chk($sformatf("vec%0d_cpu_data", i), cpu_data_o, vecs[i].e_rd);
      chk($sformatf("vec%0d_stb", i), wb_stb_o, vecs[i].e_stb);
      chk($sformatf("vec%0d_err", i), bus_err_o, vecs[i].e_err);
      advance();
    end

    // asynchronous reset in the middle of a bus cycle
    cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h600; wb_ack_i = 0; stall_i = 0; flush_i = 0;
    sample();
    advance();
    cpu_ce_i = 0;
    #1;
    chk("pre_rst_stb", wb_stb_o, 1);
    chk("pre_rst_stallreq", stallreq_o, 1);
    #1;
    rst = 0;
    #1;
    chk("mid_rst_stb", wb_stb_o, 0);
    chk("mid_rst_cyc", wb_cyc_o, 0);
    chk("mid_rst_adr", wb_adr_o, 0);
    chk("mid_rst_stallreq", stallreq_o, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    sample();
    advance();
    cpu_ce_i = 1; cpu_addr_i = 32'h700;
    sample();
    chk("post_rst_idle_req", stallreq_o, 1);
    advance();

    for (int c = 0; c < 3000; c++) begin
      cpu_ce_i   = ($urandom_range(0, 3) != 0);
      cpu_we_i   = $urandom_range(0, 1);
      cpu_addr_i = $urandom;
      cpu_data_i = $urandom;
      cpu_sel_i  = 4'($urandom_range(0, 15));
      wb_ack_i   = ($urandom_range(0, 4) == 0);
      wb_dat_i   = $urandom;
      stall_i    = ($urandom_range(0, 2) == 0) ? 6'h1f : 6'($urandom_range(0, 63));
      flush_i    = ($urandom_range(0, 15) == 0);
      sample();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_bus_if.md
Name: pipe_bus_if

Overview:
- Bus-master bridge between one pipeline memory port (instruction fetch or data access) and a Wishbone-style system bus.
- It is the requester side of the pipeline controller's stall/flush interface. It raises a stall request while a bus transaction is outstanding, and it consumes the controller's stall vector and flush.
- Two instances are used: one on the fetch port (drives the IF stall request), one on the memory port (drives the MEM stall request).

Parameters:
- STALL_BIT, 1, index into stall[5:0] that freezes the stage owning this port (1 for fetch, 3 for memory).
- TIMEOUT, 255, maximum cycles to wait for wb_ack_i before aborting (8-bit counter, 1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  6  stall vector from the pipeline controller.
- flush_i  in  1  exception flush from the pipeline controller.
- cpu_ce_i  in  1  pipeline requests an access.
- cpu_addr_i  in  32  access address.
- cpu_data_i  in  32  write data.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_sel_i  in  4  byte enables.
- cpu_data_o  out  32  read data returned to the pipeline.
- stallreq_o  out  1  stall request to the pipeline controller.
- bus_err_o  out  1  one-cycle pulse on timeout abort.
- wb_adr_o  out  32  bus address.
- wb_dat_o  out  32  bus write data.
- wb_dat_i  in  32  bus read data.
- wb_we_o  out  1  bus write enable.
- wb_sel_o  out  4  bus byte select.
- wb_stb_o  out  1  bus strobe.
- wb_cyc_o  out  1  bus cycle.
- wb_ack_i  in  1  bus acknowledge.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All wb_* outputs 0.
  - Read buffer 0, timeout counter 0, bus_err_o 0.
  - cpu_data_o=0 and stallreq_o=0 while rst=0.
- Registered outputs: wb_* and bus_err_o. Combinational outputs: stallreq_o and cpu_data_o, derived from state, cpu_ce_i, flush_i, wb_ack_i.
- States: IDLE, BUSY, WAIT_FOR_STALL.
- IDLE:
  - Combinational: stallreq_o = cpu_ce_i & ~flush_i; cpu_data_o = 0.
  - If cpu_ce_i=1 and flush_i=0: next edge latches addr/data/we/sel onto wb_*, sets wb_stb_o=wb_cyc_o=1, clears the counter, and goes to BUSY.
- BUSY:
  - If flush_i=1 (takes priority even if wb_ack_i=1): drop stb/cyc/we/sel/adr/dat to 0, clear the read buffer, go to IDLE. stallreq_o=0, cpu_data_o=0. Ack data is discarded.
  - Else if wb_ack_i=1:
    - Combinational: stallreq_o=0; cpu_data_o = wb_dat_i on a read, 0 on a write.
    - Next edge: drop stb/cyc/we/sel/adr/dat to 0 and capture wb_dat_i into the read buffer (reads only).
    - Then go to WAIT_FOR_STALL if stall_i[STALL_BIT]=1, else IDLE.
  - Else if counter == TIMEOUT-1: drop the bus signals, pulse bus_err_o=1 for one cycle, go to IDLE. stallreq_o=0 in that cycle; the access is dropped.
  - Else: counter+1, stallreq_o=1, cpu_data_o=0.
- WAIT_FOR_STALL (pipeline still frozen by another stage):
  - stallreq_o=0 and cpu_data_o = read buffer, held stable.
  - Go to IDLE when stall_i[STALL_BIT]=0 or flush_i=1.
  - flush_i also clears the read buffer.
- Never issue a new bus cycle from WAIT_FOR_STALL; the same access must not be repeated.
- Bus protocol: wb_stb_o and wb_cyc_o are always equal. Bus signals are held constant from IDLE→BUSY until the cycle ends.
- Ack in the same edge the request is issued is impossible (request is registered); ack is only sampled in BUSY.

Test Plan:
- Single read, no external stall:
  - cpu_ce_i=1, we=0, addr=0x0000_0100; slave acks on the 3rd BUSY cycle with 0xDEADBEEF.
  - Required: stallreq_o high for 3 cycles, low in the ack cycle; cpu_data_o=0xDEADBEEF in that cycle; then IDLE.
- Write with sel=4'b0011, data=0x1234_5678 to 0x0000_0200:
  - wb_we_o=1, wb_sel_o=0011, wb_dat_o held until ack.
  - Ack cycle returns cpu_data_o=0.
- Read ack while stall_i=6'b011111 (STALL_BIT=1) for 4 more cycles:
  - Enters WAIT_FOR_STALL; cpu_data_o holds the acked value and stallreq_o=0 for all 4 cycles.
  - No second wb_stb_o pulse; IDLE once stall_i[1]=0.
- flush_i=1 in BUSY, coincident with wb_ack_i=1:
  - Required: stb/cyc low next edge, cpu_data_o=0, stallreq_o=0, state IDLE.
  - Next cpu_ce_i starts a fresh cycle.
- Timeout with TIMEOUT=4 and no ack:
  - bus_err_o pulses exactly once, 4 cycles after the strobe rises; bus signals drop; stallreq_o=0.
- Reset mid-BUSY:
  - rst=0 asynchronously clears all wb_* outputs and stallreq_o immediately, without waiting for clk; state is IDLE after release.
